// File: rtl/ifid_hazard_ctrl.sv
// Front-of-pipe stall/flush sequencer: holds IF/ID, injects no-ops, gates PC and requests ID/EX bubbles.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module ifid_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int LOAD_LAT     = 1,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_redirect,
  input  logic       ext_busy,
  input  logic       halt_req,
  input  logic       resume,
  output logic       data_hazard,
  output logic       PC_hazard,
  output logic       pc_write_en,
  output logic       idex_bubble,
  output logic [2:0] state_out
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_cycles
`endif
);

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_LD_STALL = 3'd1,
    S_FLUSH    = 3'd2,
    S_EXT_WAIT = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 2);
  localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_LAT - 2);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("FLUSH_CYCLES must be in 1..15");
  end
  if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load
    $error("LOAD_LAT must be in 1..15");
  end
  if ((FLUSH_CYCLES - 2) >= (1 << CNT_W) || (LOAD_LAT - 2) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured reload values");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu;
  logic             run_eval;
  logic             dh, ph, pwe, bub;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dh        = 1'b0;
    ph        = 1'b0;
    pwe       = 1'b1;
    bub       = 1'b0;
    run_eval  = 1'b0;
    case (state)
      S_FLUSH: begin
        ph  = 1'b1;
        bub = 1'b1;
        if (ex_redirect)      cnt_nxt = FLUSH_RELOAD;
        else if (cnt == '0)   state_nxt = S_RUN;
        else                  cnt_nxt = cnt - 1'b1;
      end
      S_LD_STALL: begin
        dh  = 1'b1;
        pwe = 1'b0;
        bub = 1'b1;
        if (cnt == '0) state_nxt = S_RUN;
        else           cnt_nxt = cnt - 1'b1;
      end
      S_EXT_WAIT: begin
        // The release cycle is decided exactly as a RUN cycle, with no lost slot.
        if (ext_busy) begin
          dh  = 1'b1;
          pwe = 1'b0;
          bub = 1'b1;
        end else begin
          run_eval = 1'b1;
        end
      end
      S_HALT: begin
        dh  = 1'b1;
        pwe = 1'b0;
        bub = 1'b1;
        if (resume) state_nxt = S_RUN;
      end
      default: run_eval = 1'b1;
    endcase

    if (run_eval) begin
      state_nxt = S_RUN;
      if (ex_redirect) begin
        ph  = 1'b1;
        bub = 1'b1;
        pwe = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = FLUSH_RELOAD;
        end
      end else if (ext_busy) begin
        dh        = 1'b1;
        pwe       = 1'b0;
        bub       = 1'b1;
        state_nxt = S_EXT_WAIT;
      end else if (lu) begin
        dh  = 1'b1;
        pwe = 1'b0;
        bub = 1'b1;
        if (LOAD_LAT > 1) begin
          state_nxt = S_LD_STALL;
          cnt_nxt   = LOAD_RELOAD;
        end
      end else if (halt_req) begin
        dh        = 1'b1;
        pwe       = 1'b0;
        bub       = 1'b1;
        state_nxt = S_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Reset overrides the decode so the front end sits on no-ops while held.
  assign data_hazard = rst_n & dh;
  assign PC_hazard   = ~rst_n | ph;
  assign pc_write_en = rst_n & pwe;
  assign idex_bubble = ~rst_n | bub;
  assign state_out   = state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (dh && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (ph && (flush_cycles != 16'hFFFF)) flush_cycles <= flush_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ifid_hazard_ctrl.md
Name: ifid_hazard_ctrl

Overview:
- Central stall/flush sequencer for the front of the pipe.
- Decides each cycle whether the IF/ID register advances, holds (data_hazard), or loads a no-op (PC_hazard).
- Also gates PC update and requests a bubble into ID/EX.
- Sources it sequences: load-use dependencies, EX-stage redirects (branch/jump), busy sprite/audio/memory units, and HALT/resume.

Parameters:
- FLUSH_CYCLES, 1: cycles of no-op injection after a redirect (1..15).
- LOAD_LAT, 1: stall cycles per load-use hazard (1..15).
- CNT_W, 4: width of the internal down-counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  source register rs of the instruction in ID
- id_rt  in  5  source register rt of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch or jump
- ext_busy  in  1  sprite/audio/memory unit cannot accept work
- halt_req  in  1  ID holds a HALT instruction
- resume  in  1  external resume pulse
- data_hazard  out  1  hold IF/ID contents
- PC_hazard  out  1  load no-op into IF/ID
- pc_write_en  out  1  allow PC register update
- idex_bubble  out  1  insert no-op into ID/EX
- state_out  out  3  current FSM state, for debug

Behaviour:
- Reset: async on rst_n low. State becomes RUN and the counter 0.
  - While rst_n is low, outputs are forced to PC_hazard=1, data_hazard=0, pc_write_en=0, idex_bubble=1.
  - The first cycle after release behaves as RUN.
- States and state_out encodings: RUN=0, LD_STALL=1, FLUSH=2, EXT_WAIT=3, HALT=4. All other encodings go to RUN.
- Load-use term: lu = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- Outputs are combinational from state and current inputs (zero-latency stall). State and counter are registered.
- RUN, priority redirect > ext_busy > lu > halt_req:
  - redirect: PC_hazard=1, idex_bubble=1, pc_write_en=1 (PC takes target). If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - ext_busy: data_hazard=1, pc_write_en=0, idex_bubble=1; go to EXT_WAIT.
  - lu: data_hazard=1, pc_write_en=0, idex_bubble=1. If LOAD_LAT>1, go to LD_STALL with cnt=LOAD_LAT-2; otherwise stay in RUN.
  - halt_req: data_hazard=1, pc_write_en=0, idex_bubble=1; go to HALT.
  - none of these: all hazards 0, pc_write_en=1.
- FLUSH: PC_hazard=1, idex_bubble=1, pc_write_en=1.
  - A new ex_redirect reloads cnt=FLUSH_CYCLES-2.
  - Otherwise cnt decrements; at cnt==0, go to RUN.
- LD_STALL: data_hazard=1, pc_write_en=0, idex_bubble=1. cnt decrements; at 0, go to RUN. ext_busy, halt_req and redirect are ignored.
- EXT_WAIT: data_hazard=1, pc_write_en=0, idex_bubble=1 while ext_busy=1. The first cycle ext_busy=0 evaluates as RUN (same cycle) and the state returns to RUN.
- HALT: data_hazard=1, pc_write_en=0, idex_bubble=1.
  - resume=1 goes to RUN next cycle. resume is ignored in other states.
  - halt_req is level; a HALT still in ID after resume re-halts, so the decoder clears it.
- Invariant: data_hazard and PC_hazard are never both 1.
- Counter arithmetic is unsigned CNT_W. Parameters of 0 are illegal; synthesis asserts.
- Reset mid-stall or mid-flush: immediate return to the reset outputs. No residual count survives.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[15:0] and flush_cycles[15:0].
  - Cycles with data_hazard=1 and cycles with PC_hazard=1 are counted respectively.
  - Counters saturate at 16'hFFFF and clear on reset only.
- Undefined: ports and logic are absent. Core behaviour is identical.

Test Plan:
- Load-use, LOAD_LAT=2: ex_mem_read=1, ex_rd=5, id_rs=5 for 1 cycle -> data_hazard=1 for 2 consecutive cycles, state_out 0 then 1 then 0, pc_write_en=0 for both cycles.
- Zero register: ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall, pc_write_en=1. Also: id_rt=7, ex_rd=7, id_uses_rt=0 -> no stall.
- Redirect, FLUSH_CYCLES=3: ex_redirect pulse -> PC_hazard=1 for exactly 3 cycles. A second pulse in cycle 2 extends to 4 cycles total. data_hazard stays 0 throughout.
- Priority: ex_redirect=1, ext_busy=1, lu=1 in the same RUN cycle -> PC_hazard=1, data_hazard=0, next state FLUSH.
- ext_busy high for 4 cycles then low -> data_hazard=1 for exactly 4 cycles, pc_write_en=1 on the 5th cycle. halt_req=1 -> HALT, holds for 10 cycles; resume pulse -> RUN next cycle.
- Reset: assert rst_n=0 mid-FLUSH (cnt=1) -> outputs go to the reset values immediately. After release with idle inputs -> state_out=0, PC_hazard=0, pc_write_en=1. With HAZARD_PERF_CNT_EN: counters read 0.
